uart_rx_frame_ctrl: RTL and testbench

//  Parametrised receive-frame controller for the serial-in/parallel-out path. Generalises the
//  one-bit start/stop enable FSM into a full frame sequencer: validates the start bit at mid-bit,

---
 rtl/uart_rx_frame_ctrl_pkg.sv | 18 +
 rtl/uart_rx_frame_ctrl_rx_sync2.sv | 24 ++
 rtl/uart_rx_frame_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared UART framing definitions: frame sequencer states and line idle level,
// common to the receive controller and the matching transmitter.
package uart_rx_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    localparam logic IDLE_LEVEL = 1'b1;

    localparam int unsigned BIT_IDX_W = 4;

endpackage

// File: rtl/uart_rx_frame_ctrl_rx_sync2.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level
// so a reset never looks like a start edge.
module uart_rx_frame_ctrl_rx_sync2
    import uart_rx_frame_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= IDLE_LEVEL;
            q    <= IDLE_LEVEL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame sequencer: start validation, data shift-in, optional parity,
// 1 or 2 stop bits, parallel character with a one-cycle valid strobe and error flags.
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 os_tick,
    input  logic                 bitStream,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic [BIT_IDX_W-1:0] bit_idx
);

    localparam int unsigned SCNT_W    = $clog2(OVERSAMPLE);
    localparam int unsigned LAST_STOP = DATA_BITS + PARITY_EN + STOP_BITS;

    localparam logic [SCNT_W-1:0]    MID_SAMPLE  = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0]    FULL_SAMPLE = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_DATA_IDX = BIT_IDX_W'(DATA_BITS);
    localparam logic [BIT_IDX_W-1:0] LAST_STOP_IDX = BIT_IDX_W'(LAST_STOP);
    localparam logic                 PAR_ODD     = (PARITY_ODD != 0);
    localparam logic                 HAS_PARITY  = (PARITY_EN != 0);

    logic rx_s;

    rx_state_t              state, state_n;
    logic [SCNT_W-1:0]      scnt, scnt_n;
    logic [BIT_IDX_W-1:0]   bit_idx_n;
    logic [DATA_BITS-1:0]   shift, shift_n;
    logic                   perr, perr_n;
    logic                   ferr, ferr_n;
    logic                   stop_ferr;
    logic [DATA_BITS-1:0]   data_n;
    logic                   data_valid_n;
    logic                   parity_err_n;
    logic                   frame_err_n;
    logic                   busy_n;

    uart_rx_frame_ctrl_rx_sync2 u_rx_sync2 (
        .clk   (clk),
        .reset (reset),
        .d     (bitStream),
        .q     (rx_s)
    );

    // Frame sequencing; everything except start detection advances on os_tick only.
    always_comb begin
        state_n      = state;
        scnt_n       = scnt;
        bit_idx_n    = bit_idx;
        shift_n      = shift;
        perr_n       = perr;
        ferr_n       = ferr;
        stop_ferr    = ferr | (rx_s != IDLE_LEVEL);
        data_n       = data;
        data_valid_n = 1'b0;
        parity_err_n = parity_err;
        frame_err_n  = frame_err;

        case (state)
            IDLE: begin
                if (rx_s != IDLE_LEVEL) begin
                    state_n   = START;
                    scnt_n    = '0;
                    bit_idx_n = '0;
                    perr_n    = 1'b0;
                    ferr_n    = 1'b0;
                end
            end

            START: begin
                if (os_tick) begin
                    if (scnt == MID_SAMPLE) begin
                        // Restarting the count here puts every later sample at mid-bit.
                        scnt_n = '0;
                        if (rx_s == IDLE_LEVEL) begin
                            state_n = IDLE;
                        end else begin
                            bit_idx_n = BIT_IDX_W'(1);
                            state_n   = DATA;
                        end
                    end else begin
                        scnt_n = scnt + SCNT_W'(1);
                    end
                end
            end

            DATA: begin
                if (os_tick) begin
                    if (scnt == FULL_SAMPLE) begin
                        scnt_n    = '0;
                        shift_n   = {rx_s, shift[DATA_BITS-1:1]};
                        bit_idx_n = bit_idx + BIT_IDX_W'(1);
                        if (bit_idx == LAST_DATA_IDX) begin
                            state_n = HAS_PARITY ? PARITY : STOP;
                        end
                    end else begin
                        scnt_n = scnt + SCNT_W'(1);
                    end
                end
            end

            PARITY: begin
                if (os_tick) begin
                    if (scnt == FULL_SAMPLE) begin
                        scnt_n    = '0;
                        perr_n    = ((^shift) ^ rx_s) != PAR_ODD;
                        bit_idx_n = bit_idx + BIT_IDX_W'(1);
                        state_n   = STOP;
                    end else begin
                        scnt_n = scnt + SCNT_W'(1);
                    end
                end
            end

            STOP: begin
                if (os_tick) begin
                    if (scnt == FULL_SAMPLE) begin
                        scnt_n = '0;
                        ferr_n = stop_ferr;
                        if (bit_idx == LAST_STOP_IDX) begin
                            // Leaving at mid-stop lets a back-to-back start edge be caught.
                            data_n       = shift;
                            parity_err_n = perr;
                            frame_err_n  = stop_ferr;
                            data_valid_n = 1'b1;
                            bit_idx_n    = '0;
                            state_n      = stop_ferr ? BREAK : IDLE;
                        end else begin
                            bit_idx_n = bit_idx + BIT_IDX_W'(1);
                        end
                    end else begin
                        scnt_n = scnt + SCNT_W'(1);
                    end
                end
            end

            BREAK: begin
                if (os_tick && (rx_s == IDLE_LEVEL)) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            scnt       <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            scnt       <= scnt_n;
            bit_idx    <= bit_idx_n;
            shift      <= shift_n;
            perr       <= perr_n;
            ferr       <= ferr_n;
            data       <= data_n;
            data_valid <= data_valid_n;
            parity_err <= parity_err_n;
            frame_err  <= frame_err_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: three configurations driven with directed and random
// frames, checked every cycle against a tick-counting frame model plus literal byte expectations.
module tb_uart_rx_frame_ctrl;

    typedef struct packed {
        logic       s1;
        logic       s2;
        logic [1:0] phase;   // 0 idle, 1 in frame, 2 waiting for line high
        int         t;       // ticks since the start edge
        int         k;       // samples taken in this frame
        int         dacc;
        int         ones;
        logic       ferr;
        logic [7:0] data;
        logic       valid;
        logic       perr_o;
        logic       ferr_o;
    } mdl_t;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } lit_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_bc;
    logic tick_a, tick_b;
    logic tick_c = 1'b0;
    int   tc_cnt = 0;
    logic line_a, line_b, line_c;

    logic [7:0] data_a, data_b, data_c;
    logic       dv_a, dv_b, dv_c;
    logic       pe_a, pe_b, pe_c;
    logic       fe_a, fe_b, fe_c;
    logic       bz_a, bz_b, bz_c;
    logic [3:0] bi_a, bi_b, bi_c;

    uart_rx_frame_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(rst_a), .os_tick(tick_a), .bitStream(line_a), .data(data_a),
        .data_valid(dv_a), .parity_err(pe_a), .frame_err(fe_a), .busy(bz_a), .bit_idx(bi_a));

    uart_rx_frame_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(rst_bc), .os_tick(tick_b), .bitStream(line_b), .data(data_b),
        .data_valid(dv_b), .parity_err(pe_b), .frame_err(fe_b), .busy(bz_b), .bit_idx(bi_b));

    uart_rx_frame_ctrl #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_c (
        .clk(clk), .reset(rst_bc), .os_tick(tick_c), .bitStream(line_c), .data(data_c),
        .data_valid(dv_c), .parity_err(pe_c), .frame_err(fe_c), .busy(bz_c), .bit_idx(bi_c));

    // Oversample tick every third clock for the third configuration.
    always @(negedge clk) begin
        tc_cnt <= (tc_cnt == 2) ? 0 : tc_cnt + 1;
        tick_c <= (tc_cnt == 2);
    end

    // Frame model: sample n of a frame is taken on tick number os/2 + n*os after the start edge.
    function automatic mdl_t step(input mdl_t mi, input int os, input int pe, input int po,
                                  input int sb, input logic rst_n, input logic tick, input logic line);
        mdl_t m;
        logic rx;
        int   nsamp;
        m = mi;
        m.valid = 1'b0;
        if (!rst_n) begin
            m = '0;
            m.s1 = 1'b1;
            m.s2 = 1'b1;
            return m;
        end
        rx = m.s2;
        m.s2 = m.s1;
        m.s1 = line;
        nsamp = 1 + 8 + pe + sb;
        if (m.phase == 2'd0) begin
            if (!rx) begin
                m.phase = 2'd1; m.t = 0; m.k = 0; m.dacc = 0; m.ones = 0; m.ferr = 1'b0;
            end
        end else if (m.phase == 2'd1) begin
            if (tick) begin
                m.t = m.t + 1;
                if (m.t == os / 2 + m.k * os) begin
                    if (m.k == 0 && rx) begin
                        m.phase = 2'd0;
                    end else begin
                        if (m.k >= 1 && m.k <= 8) begin
                            m.dacc = m.dacc | (int'(rx) << (m.k - 1));
                            m.ones = m.ones + int'(rx);
                        end else if (pe != 0 && m.k == 9) begin
                            m.ones = m.ones + int'(rx);
                        end else if (m.k > 8 + pe) begin
                            m.ferr = m.ferr | !rx;
                        end
                        m.k = m.k + 1;
                        if (m.k == nsamp) begin
                            m.data   = 8'(m.dacc);
                            m.perr_o = (pe != 0) && ((m.ones % 2) != po);
                            m.ferr_o = m.ferr;
                            m.valid  = 1'b1;
                            m.phase  = m.ferr ? 2'd2 : 2'd0;
                        end
                    end
                end
            end
        end else begin
            if (tick && rx) m.phase = 2'd0;
        end
        return m;
    endfunction

    mdl_t ma, mb, mc;

    always @(posedge clk) begin
        ma <= step(ma, 16, 0, 0, 1, rst_a,  tick_a, line_a);
        mb <= step(mb, 16, 1, 0, 2, rst_bc, tick_b, line_b);
        mc <= step(mc, 8,  0, 0, 1, rst_bc, tick_c, line_c);
    end

    // Literal expectations pushed by the stimulus, consumed by the checker.
    lit_t lq [3][8];
    int   wr [3];
    int   rd [3];
    logic lit_on [3];
    logic chk_en, final_chk;
    logic final_done = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, got, want, $time);
        end
    endtask

    task automatic cmp_dut(input int i, input string dn, input logic [7:0] d, input logic v,
                           input logic pe, input logic fe, input logic bz, input logic [3:0] bi,
                           input mdl_t m);
        cmp({dn, "_valid"}, 32'(v), 32'(m.valid));
        cmp({dn, "_data"}, 32'(d), 32'(m.data));
        cmp({dn, "_parity_err"}, 32'(pe), 32'(m.perr_o));
        cmp({dn, "_frame_err"}, 32'(fe), 32'(m.ferr_o));
        cmp({dn, "_busy"}, 32'(bz), 32'(m.phase != 2'd0));
        cmp({dn, "_bit_idx"}, 32'(bi), (m.phase == 2'd1) ? 32'(m.k) : 32'd0);
        if (lit_on[i] && v === 1'b1) begin
            cmp({dn, "_lit_expected_pulse"}, 32'(rd[i] < wr[i]), 32'd1);
            if (rd[i] < wr[i]) begin
                cmp({dn, "_lit_data"}, 32'(d), 32'(lq[i][rd[i]].d));
                cmp({dn, "_lit_parity_err"}, 32'(pe), 32'(lq[i][rd[i]].pe));
                cmp({dn, "_lit_frame_err"}, 32'(fe), 32'(lq[i][rd[i]].fe));
                rd[i] = rd[i] + 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut(0, "a", data_a, dv_a, pe_a, fe_a, bz_a, bi_a, ma);
            cmp_dut(1, "b", data_b, dv_b, pe_b, fe_b, bz_b, bi_b, mb);
            cmp_dut(2, "c", data_c, dv_c, pe_c, fe_c, bz_c, bi_c, mc);
        end
        if (final_chk && !final_done) begin
            for (int i = 0; i < 3; i++) cmp("lit_all_received", 32'(rd[i]), 32'(wr[i]));
            final_done = 1'b1;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input int i, input logic v);
        case (i)
            0:       line_a = v;
            1:       line_b = v;
            default: line_c = v;
        endcase
    endtask

    task automatic send_bits(input int i, input logic [15:0] pat, input int nb, input int bclk);
        for (int j = 0; j < nb; j++) begin
            set_line(i, pat[j]);
            wait_clk(bclk);
        end
    endtask

    task automatic push_lit(input int i, input logic [7:0] d, input logic pe, input logic fe);
        lq[i][wr[i]] = '{d: d, pe: pe, fe: fe};
        wr[i] = wr[i] + 1;
    endtask

    function automatic logic [15:0] frame(input logic [7:0] d, input int pe, input logic par,
                                          input int sb, input logic s1, input logic s2);
        logic [15:0] p;
        int ix;
        p = '1;
        p[0] = 1'b0;
        p[8:1] = d;
        ix = 9;
        if (pe != 0) begin
            p[ix] = par;
            ix++;
        end
        p[ix] = s1;
        if (sb == 2) p[ix + 1] = s2;
        return p;
    endfunction

    initial begin
        rst_a = 1'b0; rst_bc = 1'b0;
        tick_a = 1'b1; tick_b = 1'b1;
        line_a = 1'b1; line_b = 1'b1; line_c = 1'b1;
        chk_en = 1'b0; final_chk = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr[i] = 0; rd[i] = 0; lit_on[i] = 1'b0;
        end
        wait_clk(4);
        chk_en = 1'b1;
        wait_clk(2);
        rst_a = 1'b1; rst_bc = 1'b1;
        wait_clk(20);
        for (int i = 0; i < 3; i++) lit_on[i] = 1'b1;

        // Plain 8N1 character.
        push_lit(0, 8'hA5, 1'b0, 1'b0);
        send_bits(0, frame(8'hA5, 0, 1'b0, 1, 1'b1, 1'b1), 10, 16);
        wait_clk(40);

        // Short low glitch must abort at the start-bit mid sample.
        set_line(0, 1'b0);
        wait_clk(5);
        set_line(0, 1'b1);
        wait_clk(40);

        // Even parity: wrong then right parity bit.
        push_lit(1, 8'h07, 1'b1, 1'b0);
        send_bits(1, frame(8'h07, 1, 1'b0, 2, 1'b1, 1'b1), 12, 16);
        wait_clk(20);
        push_lit(1, 8'h07, 1'b0, 1'b0);
        send_bits(1, frame(8'h07, 1, 1'b1, 2, 1'b1, 1'b1), 12, 16);
        wait_clk(20);

        // Second stop bit low, line held low, then a clean frame.
        push_lit(1, 8'h5A, 1'b0, 1'b1);
        send_bits(1, frame(8'h5A, 1, 1'b0, 2, 1'b1, 1'b0), 12, 16);
        wait_clk(48);
        set_line(1, 1'b1);
        wait_clk(32);
        push_lit(1, 8'h3C, 1'b0, 1'b0);
        send_bits(1, frame(8'h3C, 1, 1'b0, 2, 1'b1, 1'b1), 12, 16);
        wait_clk(40);

        // Reset in the middle of data bit 4 discards the frame.
        send_bits(0, frame(8'h3F, 0, 1'b0, 1, 1'b1, 1'b1), 5, 16);
        set_line(0, 1'b1);
        wait_clk(8);
        rst_a = 1'b0;
        wait_clk(3);
        rst_a = 1'b1;
        wait_clk(32);
        push_lit(0, 8'h81, 1'b0, 1'b0);
        send_bits(0, frame(8'h81, 0, 1'b0, 1, 1'b1, 1'b1), 10, 16);
        wait_clk(40);

        // Back-to-back frames with slow ticks.
        push_lit(2, 8'h55, 1'b0, 1'b0);
        push_lit(2, 8'hAA, 1'b0, 1'b0);
        send_bits(2, frame(8'h55, 0, 1'b0, 1, 1'b1, 1'b1), 10, 24);
        send_bits(2, frame(8'hAA, 0, 1'b0, 1, 1'b1, 1'b1), 10, 24);
        wait_clk(80);

        for (int i = 0; i < 3; i++) lit_on[i] = 1'b0;

        // Random traffic on all three receivers at once.
        fork
            begin
                for (int n = 0; n < 24; n++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    send_bits(0, frame(d, 0, 1'b0, 1, 1'b1, 1'b1), 10, 16);
                    wait_clk($urandom_range(0, 20));
                end
            end
            begin
                for (int n = 0; n < 16; n++) begin
                    logic [7:0] d;
                    logic par, s1, s2;
                    d   = 8'($urandom);
                    par = (^d) ^ ($urandom_range(0, 3) == 0);
                    s1  = ($urandom_range(0, 4) != 0);
                    s2  = ($urandom_range(0, 4) != 0);
                    send_bits(1, frame(d, 1, par, 2, s1, s2), 12, 16);
                    set_line(1, 1'b1);
                    wait_clk(16 + $urandom_range(0, 16));
                end
            end
            begin
                for (int n = 0; n < 12; n++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    send_bits(2, frame(d, 0, 1'b0, 1, 1'b1, 1'b1), 10, 24);
                    wait_clk($urandom_range(0, 30));
                end
            end
        join

        wait_clk(60);
        final_chk = 1'b1;
        wait_clk(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
